sbus_cache: RTL and testbench

// - Direct-mapped, one-word-line, write-through/no-write-allocate cache between the core's memory-stage sbus master and the memory-side sbus.
// - Serves read hits in the same cycle. Runs miss refills, uncached accesses and all writes as single-word mbus transactions through a small FSM.
// - kseg1 addresses bypass the arrays.

---
 rtl/sbus_cache.sv | 197 +++++++++++++++++++
 tb/tb_sbus_cache.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbus_cache.sv
// ============================================================================
// Module   : sbus_cache
// Purpose  : Direct-mapped, one-word-line, write-through / no-write-allocate
//            cache between the core memory-stage sbus master (cbus) and the
//            memory-side sbus (mbus). Read hits are served in the same cycle.
//            Misses, uncached (kseg1) reads and all writes run as single-word
//            mbus transactions through a small FSM.
// Ports    : clk, rst_n (async, active low)
//            cbus_* : core side slave  (en, we, size, addr, data_w in;
//                                       data_r, stall out)
//            mbus_* : memory side master (en, we, size, addr, data_w out;
//                                         data_r, stall in)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbus_cache #(
    parameter int          DEPTH        = 1024,
    parameter logic [2:0]  UNCACHED_SEG = 3'b101
) (
    input  logic        clk,
    input  logic        rst_n,
    // core side
    input  logic        cbus_en,
    input  logic        cbus_we,
    input  logic [1:0]  cbus_size,
    input  logic [31:0] cbus_addr,
    input  logic [31:0] cbus_data_w,
    output logic [31:0] cbus_data_r,
    output logic        cbus_stall,
    // memory side
    output logic        mbus_en,
    output logic        mbus_we,
    output logic [1:0]  mbus_size,
    output logic [31:0] mbus_addr,
    output logic [31:0] mbus_data_w,
    input  logic [31:0] mbus_data_r,
    input  logic        mbus_stall
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REFILL   = 3'd1;
    localparam logic [2:0] S_UNCACHED = 3'd2;
    localparam logic [2:0] S_WRITE    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [31:0]      word;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             uncached;
    logic             hit;
    logic             mem_done;
    logic             refill_done;
    logic             uncached_done;
    logic             write_done;

    assign idx      = cbus_addr[IDX_W+1:2];
    assign tag      = cbus_addr[31:IDX_W+2];
    assign uncached = (cbus_addr[31:29] == UNCACHED_SEG);
    // The request is held stable while stalled, so this lookup is equally
    // valid in IDLE and at the WRITE completion.
    assign hit      = !uncached && valid[idx] && (tag_mem[idx] == tag);

    assign mem_done      = !mbus_stall &&
                           ((state == S_REFILL) || (state == S_UNCACHED) ||
                            (state == S_WRITE));
    assign refill_done   = mem_done && (state == S_REFILL);
    assign uncached_done = mem_done && (state == S_UNCACHED);
    assign write_done    = mem_done && (state == S_WRITE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cbus_en) begin
                    if (cbus_we)       state_nxt = S_WRITE;
                    else if (uncached) state_nxt = S_UNCACHED;
                    else if (!hit)     state_nxt = S_REFILL;
                end
            end
            S_REFILL, S_UNCACHED, S_WRITE: begin
                if (!mbus_stall) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are forced to zero while rst_n is low so that an abandoned
    // memory access releases the bus without waiting for a clock edge.
    always_comb begin
        cbus_stall  = 1'b0;
        cbus_data_r = 32'd0;
        mbus_en     = 1'b0;
        mbus_we     = 1'b0;
        mbus_size   = 2'd0;
        mbus_addr   = 32'd0;
        mbus_data_w = 32'd0;
        case (state)
            S_IDLE: begin
                if (cbus_en) begin
                    if (!cbus_we && !uncached && hit) begin
                        cbus_data_r = data_mem[idx];
                    end else begin
                        cbus_stall = 1'b1;
                    end
                end
            end
            S_REFILL: begin
                cbus_stall = 1'b1;
                mbus_en    = 1'b1;
                mbus_size  = 2'd2;
                mbus_addr  = {cbus_addr[31:2], 2'b00};
            end
            S_UNCACHED: begin
                cbus_stall = 1'b1;
                mbus_en    = 1'b1;
                mbus_size  = cbus_size;
                mbus_addr  = cbus_addr;
            end
            S_WRITE: begin
                cbus_stall  = 1'b1;
                mbus_en     = 1'b1;
                mbus_we     = 1'b1;
                mbus_size   = cbus_size;
                mbus_addr   = cbus_addr;
                mbus_data_w = cbus_data_w;
            end
            S_DONE: begin
                cbus_data_r = word;
            end
            default: ;
        endcase
        if (!rst_n) begin
            cbus_stall  = 1'b0;
            cbus_data_r = 32'd0;
            mbus_en     = 1'b0;
            mbus_we     = 1'b0;
            mbus_size   = 2'd0;
            mbus_addr   = 32'd0;
            mbus_data_w = 32'd0;
        end
    end

    // ------------------------------------------------------------- arrays
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (refill_done) begin
            valid[idx] <= 1'b1;
        end else if (write_done && hit && (cbus_size != 2'd2)) begin
            // Partial writes invalidate rather than merge into the line.
            valid[idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (refill_done) begin
            data_mem[idx] <= mbus_data_r;
            tag_mem[idx]  <= tag;
        end else if (write_done && hit && (cbus_size == 2'd2)) begin
            data_mem[idx] <= cbus_data_w;
        end
    end

    // Word returned to the core during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= 32'd0;
        end else if (refill_done || uncached_done) begin
            word <= mbus_data_r;
        end else if (write_done) begin
            word <= 32'd0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sbus_cache.sv
// ============================================================================
// Module   : tb_sbus_cache
// Purpose  : Directed self-checking bench for sbus_cache with a simple
//            memory responder that inserts a programmable number of waits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sbus_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cbus_en = 1'b0;
    logic        cbus_we = 1'b0;
    logic [1:0]  cbus_size = 2'd0;
    logic [31:0] cbus_addr = 32'd0;
    logic [31:0] cbus_data_w = 32'd0;
    logic [31:0] cbus_data_r;
    logic        cbus_stall;
    logic        mbus_en;
    logic        mbus_we;
    logic [1:0]  mbus_size;
    logic [31:0] mbus_addr;
    logic [31:0] mbus_data_w;
    logic [31:0] mbus_data_r;
    logic        mbus_stall;

    int total = 0;
    int bad   = 0;

    // memory responder
    int          waits = 0;
    int          wcnt  = 0;
    logic [31:0] mem_word = 32'd0;
    int          txn_cnt = 0;
    logic        last_we;
    logic [1:0]  last_size;
    logic [31:0] last_addr;
    logic [31:0] last_data_w;

    // access results
    logic [31:0] rd;
    int          stalls;
    bit          saw_m;

    always #5 clk = ~clk;

    assign mbus_stall  = mbus_en && (wcnt < waits);
    assign mbus_data_r = mem_word;

    always @(posedge clk) begin
        if (!mbus_en) begin
            wcnt <= 0;
        end else if (mbus_stall) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt        <= 0;
            txn_cnt     <= txn_cnt + 1;
            last_we     <= mbus_we;
            last_size   <= mbus_size;
            last_addr   <= mbus_addr;
            last_data_w <= mbus_data_w;
        end
    end

    sbus_cache dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cbus_en     (cbus_en),
        .cbus_we     (cbus_we),
        .cbus_size   (cbus_size),
        .cbus_addr   (cbus_addr),
        .cbus_data_w (cbus_data_w),
        .cbus_data_r (cbus_data_r),
        .cbus_stall  (cbus_stall),
        .mbus_en     (mbus_en),
        .mbus_we     (mbus_we),
        .mbus_size   (mbus_size),
        .mbus_addr   (mbus_addr),
        .mbus_data_w (mbus_data_w),
        .mbus_data_r (mbus_data_r),
        .mbus_stall  (mbus_stall)
    );

    // One core request held until it retires; records stall cycles,
    // returned word and whether mbus was touched.
    task automatic access(input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        cbus_en = 1'b1; cbus_we = we; cbus_size = size;
        cbus_addr = addr; cbus_data_w = wdata;
        stalls = 0; saw_m = 1'b0; rd = 32'hxxxxxxxx;
        forever begin
            @(negedge clk);
            if (mbus_en) saw_m = 1'b1;
            if (!cbus_stall) begin
                rd = cbus_data_r;
                break;
            end
            stalls++;
            if (stalls > 20) begin
                total++; bad++;
                $display("FAIL timeout addr=%h: stall never dropped", addr);
                break;
            end
        end
        @(posedge clk);
        #1;
        cbus_en = 1'b0; cbus_we = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (cbus_stall !== 1'b0 || cbus_data_r !== 32'd0 || mbus_en !== 1'b0 ||
            mbus_we !== 1'b0 || mbus_addr !== 32'd0 || mbus_size !== 2'd0 ||
            mbus_data_w !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs got stall=%b dr=%h men=%b mwe=%b maddr=%h need all 0",
                     cbus_stall, cbus_data_r, mbus_en, mbus_we, mbus_addr);
        end
        #20 rst_n = 1'b1;
    endtask

    task automatic test_refill();
        int t0;
        waits = 1; mem_word = 32'h12345678; t0 = txn_cnt;
        access(1'b0, 2'd2, 32'h80000010, 32'd0);
        total++;
        if (stalls != 3 || rd !== 32'h12345678) begin
            bad++;
            $display("FAIL refill got stalls=%0d data=%h need 3 12345678", stalls, rd);
        end
        total++;
        if (txn_cnt != t0 + 1 || last_addr !== 32'h80000010 || last_size !== 2'd2 ||
            last_we !== 1'b0) begin
            bad++;
            $display("FAIL refill_mbus got n=%0d addr=%h size=%0d we=%b need 1 80000010 2 0",
                     txn_cnt - t0, last_addr, last_size, last_we);
        end
        // reread with different low address bits must still hit
        t0 = txn_cnt;
        access(1'b0, 2'd1, 32'h80000012, 32'd0);
        total++;
        if (stalls != 0 || saw_m || rd !== 32'h12345678 || txn_cnt != t0) begin
            bad++;
            $display("FAIL reread_hit got stalls=%0d mbus=%b data=%h need 0 0 12345678",
                     stalls, saw_m, rd);
        end
    endtask

    task automatic test_uncached();
        int t0;
        waits = 0; mem_word = 32'h3C1D0001; t0 = txn_cnt;
        access(1'b0, 2'd1, 32'hBFC00002, 32'd0);
        total++;
        if (stalls != 2 || rd !== 32'h3C1D0001 || last_addr !== 32'hBFC00002 ||
            last_size !== 2'd1 || txn_cnt != t0 + 1) begin
            bad++;
            $display("FAIL uncached got stalls=%0d data=%h addr=%h size=%0d need 2 3c1d0001 bfc00002 1",
                     stalls, rd, last_addr, last_size);
        end
        access(1'b0, 2'd1, 32'hBFC00002, 32'd0);
        total++;
        if (stalls != 2 || !saw_m || txn_cnt != t0 + 2) begin
            bad++;
            $display("FAIL uncached_again got stalls=%0d mbus=%b n=%0d need 2 1 2",
                     stalls, saw_m, txn_cnt - t0);
        end
    endtask

    task automatic test_conflict();
        waits = 0;
        access(1'b0, 2'd2, 32'h80000010, 32'd0);
        total++;
        if (stalls != 0 || rd !== 32'h12345678) begin
            bad++;
            $display("FAIL conflict_hit got stalls=%0d data=%h need 0 12345678", stalls, rd);
        end
        mem_word = 32'hCAFEF00D;
        access(1'b0, 2'd2, 32'h80001010, 32'd0);
        total++;
        if (stalls != 2 || rd !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL conflict_miss got stalls=%0d data=%h need 2 cafef00d", stalls, rd);
        end
        mem_word = 32'h11112222;
        access(1'b0, 2'd2, 32'h80000010, 32'd0);
        total++;
        if (stalls != 2 || rd !== 32'h11112222) begin
            bad++;
            $display("FAIL conflict_evict got stalls=%0d data=%h need 2 11112222", stalls, rd);
        end
    endtask

    task automatic test_write();
        waits = 0;
        access(1'b1, 2'd2, 32'h80000010, 32'hDEADBEEF);
        total++;
        if (stalls != 2 || rd !== 32'd0 || last_we !== 1'b1 || last_size !== 2'd2 ||
            last_addr !== 32'h80000010 || last_data_w !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_word got stalls=%0d dr=%h we=%b size=%0d addr=%h dw=%h need 2 0 1 2 80000010 deadbeef",
                     stalls, rd, last_we, last_size, last_addr, last_data_w);
        end
        access(1'b0, 2'd2, 32'h80000010, 32'd0);
        total++;
        if (stalls != 0 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_then_hit got stalls=%0d data=%h need 0 deadbeef", stalls, rd);
        end
        access(1'b1, 2'd0, 32'h80000011, 32'h0000AA00);
        total++;
        if (stalls != 2 || last_size !== 2'd0 || last_addr !== 32'h80000011 ||
            last_we !== 1'b1) begin
            bad++;
            $display("FAIL write_byte got stalls=%0d size=%0d addr=%h we=%b need 2 0 80000011 1",
                     stalls, last_size, last_addr, last_we);
        end
        mem_word = 32'h55667788;
        access(1'b0, 2'd2, 32'h80000010, 32'd0);
        total++;
        if (stalls != 2 || rd !== 32'h55667788) begin
            bad++;
            $display("FAIL byte_invalidates got stalls=%0d data=%h need 2 55667788", stalls, rd);
        end
    endtask

    task automatic test_reset_mid();
        // 0x80000010 is cached at this point
        waits = 5;
        @(posedge clk);
        #1;
        cbus_en = 1'b1; cbus_we = 1'b0; cbus_size = 2'd2; cbus_addr = 32'h80000020;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (mbus_en !== 1'b1 || mbus_stall !== 1'b1) begin
            bad++;
            $display("FAIL mid_refill_active got men=%b mstall=%b need 1 1", mbus_en, mbus_stall);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mbus_en !== 1'b0 || cbus_stall !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got men=%b stall=%b need 0 0", mbus_en, cbus_stall);
        end
        cbus_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        waits = 0; mem_word = 32'h00000099;
        access(1'b0, 2'd2, 32'h80000010, 32'd0);
        total++;
        if (stalls != 2 || rd !== 32'h00000099) begin
            bad++;
            $display("FAIL reset_invalidates got stalls=%0d data=%h need 2 00000099", stalls, rd);
        end
    endtask

    task automatic test_write_miss();
        int t0;
        waits = 0; t0 = txn_cnt;
        access(1'b1, 2'd2, 32'h80002000, 32'h01020304);
        total++;
        if (stalls != 2 || txn_cnt != t0 + 1 || last_we !== 1'b1 ||
            last_addr !== 32'h80002000 || last_data_w !== 32'h01020304) begin
            bad++;
            $display("FAIL write_miss got stalls=%0d n=%0d we=%b addr=%h dw=%h need 2 1 1 80002000 01020304",
                     stalls, txn_cnt - t0, last_we, last_addr, last_data_w);
        end
        mem_word = 32'h0A0B0C0D;
        access(1'b0, 2'd2, 32'h80002000, 32'd0);
        total++;
        if (stalls != 2 || rd !== 32'h0A0B0C0D) begin
            bad++;
            $display("FAIL no_allocate got stalls=%0d data=%h need 2 0a0b0c0d", stalls, rd);
        end
    endtask

    initial begin
        test_reset();
        test_refill();
        test_uncached();
        test_conflict();
        test_write();
        test_reset_mid();
        test_write_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
